serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

Serial bit-pattern transmitter: the generator end of the team's serial sequence-detector path. It latches an N-bit pattern on a start request and shifts it out MSB-first, one bit per clock, on a single serial line. It can repeat the frame a programmable number of times with a fixed idle gap between frames. It drives the serial input of the 101-sequence detectors and serves as the stimulus source for on-chip detector checks.

## Interface
- N, 8: bits per frame; legal range N >= 2
- GAP, 2: idle cycles between repeated frames; legal range GAP >= 0, where 0 means back-to-back frames
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  input  1  transmit request; sampled only in IDLE
- data  input  N  pattern; latched when start is accepted
- repeat_cnt  input  4  extra repetitions; frames sent = repeat_cnt + 1; latched with data
- a  output  1  serial bit; MSB first
- a_valid  output  1  high while a carries a pattern bit
- busy  output  1  high from the first bit through the last bit or gap cycle
- done  output  1  one-cycle pulse after the final bit

## Operation
- All outputs are registered.
- Reset (rst=0 at an edge): state=IDLE; a=0, a_valid=0, busy=0, done=0; shift register, bit counter, gap counter and repeat counter cleared.
- Reset has priority over every other input, including mid-frame. A frame in progress is abandoned with no done pulse.
- **IDLE**: a=0, a_valid=0, busy=0.
  - start=1 at an edge: latch data into the shift register and repeat_cnt into the repeat counter; load bit counter = N-1.
  - Same edge: a<=data[N-1], a_valid<=1, busy<=1; go to SEND.
- **SEND**: each edge shifts the pattern left; a presents the next bit.
  - After N bits, if the repeat counter = 0: go to IDLE; a<=0, a_valid<=0, busy<=0, done<=1 for exactly one cycle.
  - After N bits, if the repeat counter > 0: decrement it and reload the shift register from the latched pattern.
    - GAP > 0: go to GAP; a<=0, a_valid<=0, busy stays 1.
    - GAP = 0: go directly to the first bit of the next frame, so a_valid stays 1.
- **GAP**: a=0, a_valid=0, busy=1 for exactly GAP cycles, then go to SEND with the MSB presented.
- start is ignored while busy=1. It is not queued.
- data and repeat_cnt changes after acceptance have no effect on the transfer in progress.
- start=1 during the done-pulse cycle (state is IDLE) is accepted. done and busy are then never high in the same cycle; the new first bit appears the following cycle.
- Repeat counter is 4 bits. repeat_cnt=15 yields 16 frames with no wrap or overflow.

## Timing
- Latency: start sampled at edge T → MSB valid on a during cycle T+1.
- Frame length: N cycles with a_valid=1 continuously.
- Total busy cycles: (R+1)*N + R*GAP, where R = repeat_cnt.
- done is high in the single cycle immediately after the last bit, with busy=0 in that cycle.
- Earliest back-to-back restart: start held high continuously gives one IDLE (done) cycle between transfers.
- a is 0 whenever a_valid=0.

## Test plan
- **Reset values**: hold rst=0 for 3 cycles, then release → a=0, a_valid=0, busy=0, done=0; no activity without start.
- **Single frame** (N=8, GAP=2): data=8'hA5, repeat_cnt=0, start pulse at T → cycles T+1..T+8 give a = 1,0,1,0,0,1,0,1 with a_valid=1; done=1 only at T+9; busy=0 at T+9.
- **Repeat with gap**: data=8'h05, repeat_cnt=2 → three 8-bit frames separated by 2 cycles of a=0/a_valid=0.
  - busy is high for exactly 28 cycles; one done pulse.
  - Fed to the 101 detector, it flags every 101 occurrence, including across frame boundaries where applicable.
- **GAP=0 build**: data=8'hC3, repeat_cnt=1 → 16 consecutive a_valid cycles reading 11000011 11000011; busy high 16 cycles.
- **Start while busy**: second start pulse at T+4 with data=8'hFF → ignored; transmitted bits still match 8'hA5; exactly one done pulse.
- **Reset mid-frame**: rst=0 at T+5 of an 8'hA5 transfer → next cycle all outputs 0, no done pulse; a new start afterwards transmits cleanly from the MSB.

Source files
------------

// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_tx
// Function : Latches an N-bit pattern on start and shifts it out MSB-first,
//            repeating it repeat_cnt+1 times with a GAP-cycle idle gap.
// Revision : 1.0  initial release
// ============================================================================
module serial_pattern_tx #(
  parameter int N   = 8,
  parameter int GAP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] data,
  input  logic [3:0]   repeat_cnt,
  output logic         a,
  output logic         a_valid,
  output logic         busy,
  output logic         done
);

  localparam int BW = $clog2(N);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   pattern;
  logic [N-1:0]   shreg;
  logic [BW-1:0]  bit_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [3:0]     rep;

  // shreg holds the bits still to be sent, aligned to its MSB; a always
  // carries the bit currently on the line, so bit_cnt counts bits remaining.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      pattern <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      rep     <= '0;
      a       <= 1'b0;
      a_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pattern <= data;
            shreg   <= {data[N-2:0], 1'b0};
            rep     <= repeat_cnt;
            bit_cnt <= LAST_BIT;
            a       <= data[N-1];
            a_valid <= 1'b1;
            busy    <= 1'b1;
            state   <= S_SEND;
          end
        end

        S_SEND: begin
          if (bit_cnt != '0) begin
            a       <= shreg[N-1];
            shreg   <= {shreg[N-2:0], 1'b0};
            bit_cnt <= bit_cnt - BW'(1);
          end else if (rep == 4'd0) begin
            a       <= 1'b0;
            a_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_IDLE;
          end else begin
            rep <= rep - 4'd1;
            if (GAP > 0) begin
              a       <= 1'b0;
              a_valid <= 1'b0;
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end else begin
              // back-to-back: next frame's MSB follows the last bit directly
              a       <= pattern[N-1];
              shreg   <= {pattern[N-2:0], 1'b0};
              bit_cnt <= LAST_BIT;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else begin
            a       <= pattern[N-1];
            shreg   <= {pattern[N-2:0], 1'b0};
            bit_cnt <= LAST_BIT;
            a_valid <= 1'b1;
            state   <= S_SEND;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_tx
// Function : Self-checking bench for serial_pattern_tx (GAP=2 and GAP=0 builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start2 = 1'b0;
  logic       start0 = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] repc = 4'd0;
  logic       a2, av2, b2, d2;
  logic       a0, av0, b0, d0;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [7:0] d;
    logic [3:0] r;
    bit         g0;
    bit         noisy;
    int         exp_busy;
    int         exp_valid;
  } vec_t;

  vec_t vt[6];

  always #5 clk = ~clk;

  serial_pattern_tx #(.N(8), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .start(start2), .data(data), .repeat_cnt(repc),
    .a(a2), .a_valid(av2), .busy(b2), .done(d2)
  );

  serial_pattern_tx #(.N(8), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .start(start0), .data(data), .repeat_cnt(repc),
    .a(a0), .a_valid(av0), .busy(b0), .done(d0)
  );

  function automatic logic [3:0] obs(input bit g0);
    return g0 ? {a0, av0, b0, d0} : {a2, av2, b2, d2};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: each frame is the pattern MSB-first, frames separated by gap
  // idle-but-busy cycles, then one done cycle and a quiet idle cycle.
  task automatic build(input logic [7:0] d, input int r, input int gap);
    exp_q.delete();
    for (int f = 0; f <= r; f++) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], 1'b1, 1'b1, 1'b0});
      if (f < r)
        for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endtask

  task automatic run_xfer(input bit g0, input logic [7:0] d, input logic [3:0] r,
                          input bit noisy, input int inj_k,
                          output int nb, output int nv, output int nd);
    logic [3:0] o;
    logic       s;
    build(d, int'(r), g0 ? 0 : 2);
    nb = 0; nv = 0; nd = 0;
    @(negedge clk);
    data = d;
    repc = r;
    if (g0) start0 = 1'b1; else start2 = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk);
      #1;
      o = obs(g0);
      checks++;
      if (o !== exp_q[k]) begin
        errors++;
        $display("FAIL xfer d=%h r=%0d g0=%0d cyc %0d: a/av/busy/done got %b expected %b",
                 d, r, g0, k, o, exp_q[k]);
      end
      nb += int'(o[1]);
      nv += int'(o[2]);
      nd += int'(o[0]);
      // start must only be raised while the DUT is busy, where it is ignored
      s = 1'b0;
      if (exp_q[k][1]) begin
        if (noisy) begin
          s    = 1'($urandom_range(0, 1));
          data = 8'($urandom);
          repc = 4'($urandom);
        end
        if (k == inj_k) begin
          s    = 1'b1;
          data = 8'hFF;
        end
      end
      if (g0) start0 = s; else start2 = s;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, nv, nd;
    logic [7:0] rd;
    logic [3:0] rr;
    bit         rg;

    vt[0] = '{8'hA5, 4'd0,  1'b0, 1'b0, 8,   8};
    vt[1] = '{8'h05, 4'd2,  1'b0, 1'b0, 28,  24};
    vt[2] = '{8'hC3, 4'd1,  1'b1, 1'b0, 16,  16};
    vt[3] = '{8'hFF, 4'd15, 1'b0, 1'b1, 158, 128};
    vt[4] = '{8'h5A, 4'd1,  1'b0, 1'b1, 18,  16};
    vt[5] = '{8'h81, 4'd15, 1'b1, 1'b1, 128, 128};

    // reset values
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset outputs g2", int'(obs(1'b0)), 0);
      chk("reset outputs g0", int'(obs(1'b1)), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("idle no start g2", int'(obs(1'b0)), 0);
      chk("idle no start g0", int'(obs(1'b1)), 0);
    end

    foreach (vt[i]) begin
      run_xfer(vt[i].g0, vt[i].d, vt[i].r, vt[i].noisy, -1, nb, nv, nd);
      chk($sformatf("vec%0d busy cycles", i), nb, vt[i].exp_busy);
      chk($sformatf("vec%0d valid cycles", i), nv, vt[i].exp_valid);
      chk($sformatf("vec%0d done pulses", i), nd, 1);
    end

    // second start at T+4 with a different pattern is ignored
    run_xfer(1'b0, 8'hA5, 4'd0, 1'b0, 2, nb, nv, nd);
    chk("busy-start done pulses", nd, 1);
    chk("busy-start busy cycles", nb, 8);

    // reset in the middle of a frame
    @(negedge clk);
    data   = 8'hA5;
    repc   = 4'd3;
    start2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      start2 = 1'b0;
      chk($sformatf("pre-reset bit %0d", k), int'(obs(1'b0)),
          int'({(k == 0 || k == 2) ? 1'b1 : 1'b0, 3'b110}));
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid-frame reset outputs", int'(obs(1'b0)), 0);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("post-reset quiet", int'(obs(1'b0)), 0);
    end
    run_xfer(1'b0, 8'hA5, 4'd0, 1'b0, -1, nb, nv, nd);
    chk("post-reset done pulses", nd, 1);

    // randomized transfers with busy-time input noise
    for (int t = 0; t < 24; t++) begin
      rd = 8'($urandom);
      rr = 4'($urandom_range(0, 3));
      rg = 1'($urandom_range(0, 1));
      run_xfer(rg, rd, rr, 1'b1, -1, nb, nv, nd);
      chk($sformatf("rand%0d busy cycles", t), nb,
          (int'(rr) + 1) * 8 + int'(rr) * (rg ? 0 : 2));
      chk($sformatf("rand%0d done pulses", t), nd, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
